mux_4to1_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 multiplexer between four requesters. It samples a 4-bit request vector and picks one owner. It drives the multiplexer select lines and the active-low enable so that only the owner's data reaches the output, and it bounds each grant to a fixed number of cycles. Between grants it inserts a one-cycle turnaround with the multiplexer disabled, so ownership never changes while the output is enabled.

---
 rtl/mux_4to1_arbiter_if.sv | 18 +
 rtl/mux_4to1_arbiter.sv | 112 +++++++++++
 tb/tb_mux_4to1_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mux_4to1_arbiter_if.sv
// Request/grant bundle between the four requesters and the 4-to-1 mux arbiter.
interface mux_4to1_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] signal_sel;
  logic       enable_;
  logic       busy;

  modport master (
    output req,
    input  grant, signal_sel, enable_, busy
  );

  modport slave (
    input  req,
    output grant, signal_sel, enable_, busy
  );
endinterface

// File: rtl/mux_4to1_arbiter.sv
// Arbiter sharing a 4-to-1 mux: bounded grants separated by a one-cycle disabled turnaround.
// Define MUX_4TO1_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 highest).
module mux_4to1_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  mux_4to1_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]       state;
  logic [3:0]       grant_q;
  logic [1:0]       sel_q;
  logic             enable_q;
  logic             busy_q;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       winner;
  logic             found;
  logic             any_req;

`ifdef MUX_4TO1_ARB_RR_EN
  logic [1:0] last;
`endif

  assign any_req = |bus.req;

  // Scan starts just past the previous owner, so it is re-granted only when nobody else asks.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
`ifdef MUX_4TO1_ARB_RR_EN
    for (int i = 1; i <= 4; i++) begin
      if (!found && bus.req[last + 2'(i)]) begin
        winner = last + 2'(i);
        found  = 1'b1;
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (!found && bus.req[i]) begin
        winner = 2'(i);
        found  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_q  <= 4'b0000;
      sel_q    <= 2'b00;
      enable_q <= 1'b1;
      busy_q   <= 1'b0;
      hold_cnt <= '0;
`ifdef MUX_4TO1_ARB_RR_EN
      last     <= 2'b11;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_TURN: begin
          if (any_req) begin
            state    <= ST_GRANT;
            grant_q  <= 4'b0001 << winner;
            sel_q    <= winner;
            enable_q <= 1'b0;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
`ifdef MUX_4TO1_ARB_RR_EN
            last     <= winner;
`endif
          end else begin
            state    <= ST_IDLE;
            grant_q  <= 4'b0000;
            enable_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Release on owner drop or once the hold budget is spent; sel stays put.
          if (!bus.req[sel_q] || hold_cnt == HOLD_MAX) begin
            state    <= ST_TURN;
            grant_q  <= 4'b0000;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          grant_q  <= 4'b0000;
          enable_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.signal_sel = sel_q;
  assign bus.enable_    = enable_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// Randomized bench for mux_4to1_arbiter: behavioural ownership model plus literal scenario checks.
// Follows MUX_4TO1_ARB_RR_EN the same way the design does.
module tb_mux_4to1_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  mux_4to1_arbiter_if bus ();

  mux_4to1_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = idle, 1 = granted, 2 = turnaround; held counts cycles owned so far.
  int   m_phase = 0;
  int   m_owner = -1;
  int   m_sel = 0;
  int   m_last = 3;
  int   m_held = 0;
  bit   model_valid = 1'b0;

  function automatic int pick_winner(input logic [3:0] r);
`ifdef MUX_4TO1_ARB_RR_EN
    for (int off = 1; off <= 4; off++) begin
      if (r[(m_last + off) % 4]) return (m_last + off) % 4;
    end
`else
    for (int c = 0; c < 4; c++) begin
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_phase = 0; m_owner = -1; m_sel = 0; m_last = 3; m_held = 0;
      model_valid = 1'b1;
    end else if (m_phase == 1) begin
      if (!bus.req[m_owner] || m_held == HOLD) begin
        m_phase = 2;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (bus.req != 4'b0000) begin
      w = pick_winner(bus.req);
      m_phase = 1; m_owner = w; m_sel = w; m_last = w; m_held = 1;
    end else begin
      m_phase = 0;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check_value(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic check_output();
    int exp_grant;
    exp_grant = (m_owner < 0) ? 0 : (1 << m_owner);
    check_value("model grant", int'(bus.grant), exp_grant);
    check_value("model signal_sel", int'(bus.signal_sel), m_sel);
    check_value("model enable_", int'(bus.enable_), (m_phase == 1) ? 0 : 1);
    check_value("model busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (model_valid) check_output();
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
  endtask

  task automatic pulse_reset();
    apply_stimulus(4'b0000, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic en);
    check_value({name, " grant"}, int'(bus.grant), int'(g));
    check_value({name, " sel"}, int'(bus.signal_sel), int'(s));
    check_value({name, " enable_"}, int'(bus.enable_), int'(en));
  endtask

  initial begin
    apply_stimulus(4'b0000, 1'b1);
    tick();
    tick();
    expect_out("reset", 4'b0000, 2'b00, 1'b1);
    check_value("reset busy", int'(bus.busy), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 4'b0000, 2'b00, 1'b1);
    end

    // Single requester: 4-cycle grants separated by one turnaround.
    pulse_reset();
    bus.req = 4'b0100;
    for (int rep = 0; rep < 2; rep++) begin
      for (int j = 0; j < HOLD; j++) begin
        tick();
        expect_out("single grant", 4'b0100, 2'b10, 1'b0);
      end
      tick();
      expect_out("single turn", 4'b0000, 2'b10, 1'b1);
    end
    tick();
    expect_out("single regrant", 4'b0100, 2'b10, 1'b0);

`ifdef MUX_4TO1_ARB_RR_EN
    pulse_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < HOLD; j++) begin
        tick();
        expect_out("rotate grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
      end
      tick();
      expect_out("rotate turn", 4'b0000, 2'(k % 4), 1'b1);
    end
`else
    pulse_reset();
    bus.req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < HOLD; j++) begin
        tick();
        expect_out("priority grant", 4'b0010, 2'b01, 1'b0);
      end
      tick();
      expect_out("priority turn", 4'b0000, 2'b01, 1'b1);
    end
`endif

    // Early release: owner 0 drops after two cycles.
    pulse_reset();
    bus.req = 4'b0011;
    tick();
    expect_out("early c1", 4'b0001, 2'b00, 1'b0);
    tick();
    expect_out("early c2", 4'b0001, 2'b00, 1'b0);
    bus.req = 4'b0010;
    tick();
    expect_out("early turn", 4'b0000, 2'b00, 1'b1);
    tick();
    expect_out("early next", 4'b0010, 2'b01, 1'b0);

    // Reset in the second cycle of a grant to requester 3.
    pulse_reset();
    bus.req = 4'b1000;
    tick();
    expect_out("midrst c1", 4'b1000, 2'b11, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    expect_out("midrst reset", 4'b0000, 2'b00, 1'b1);
    check_value("midrst busy", int'(bus.busy), 0);
    rst = 1'b0;
    tick();
    expect_out("midrst regrant", 4'b1000, 2'b11, 1'b0);

    // Random traffic with sticky requests and occasional reset, checked by the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) bus.req = 4'($urandom_range(15));
      rst = ($urandom_range(59) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
